// File: rtl/bin_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin_bcd_seq_pkg;

    localparam int BCD_W      = 4;
    localparam int ADJ_THRESH = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bin_bcd_seq_if.sv
// Host-side bus of bin_bcd_seq: write strobe, operand and registered results.
// The sign signal exists only when BIN_BCD_SIGNED_EN is defined.
interface bin_bcd_seq_if #(
    parameter int BIN_W  = 27,
    parameter int DIGITS = 8
);
    logic                  digcs;
    logic                  digwrite;
    logic [BIN_W-1:0]      binary;
    logic [4*DIGITS-1:0]   decimal;
    logic                  busy;
    logic                  done;
    logic                  overflow;
`ifdef BIN_BCD_SIGNED_EN
    logic                  sign;

    modport master (output digcs, digwrite, binary,
                    input  decimal, busy, done, overflow, sign);
    modport slave  (input  digcs, digwrite, binary,
                    output decimal, busy, done, overflow, sign);
`else
    modport master (output digcs, digwrite, binary,
                    input  decimal, busy, done, overflow);
    modport slave  (input  digcs, digwrite, binary,
                    output decimal, busy, done, overflow);
`endif
endinterface

// File: rtl/bin_bcd_seq_digit_adj.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_digit_adj
    import bin_bcd_seq_pkg::*;
(
    input  logic [BCD_W-1:0] din,
    output logic [BCD_W-1:0] dout
);

    assign dout = (din >= BCD_W'(ADJ_THRESH)) ? din + BCD_W'(3) : din;

endmodule

// File: rtl/bin_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter; optional BIN_BCD_SIGNED_EN converts two's complement.
// Result and done appear BIN_W+1 edges after a write; writes while busy park in a one-deep latest-wins slot.
module bin_bcd_seq
    import bin_bcd_seq_pkg::*;
#(
    parameter int BIN_W  = 27,
    parameter int DIGITS = 8
) (
    input logic          clock,
    input logic          reset_n,
    bin_bcd_seq_if.slave bus
);

    localparam int DEC_W = BCD_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W);

    state_t             state, state_nxt;
    logic [BIN_W-1:0]   sh_q;
    logic [DEC_W-1:0]   dig_q;
    logic [DEC_W-1:0]   dig_adj;
    logic [DIGITS-1:0]  dig_bad;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_q;
    logic               pend_vld;
    logic [BIN_W-1:0]   pend_dat;
    logic [DEC_W-1:0]   dec_q;
    logic               ovf_out_q;
    logic               done_q;
    logic               wr;
    logic               start;
    logic [BIN_W-1:0]   start_val;
    logic [BIN_W-1:0]   start_mag;

    assign wr    = bus.digcs && bus.digwrite;
    assign start = ((state == IDLE) && wr) || ((state == DONE) && (wr || pend_vld));

    // A write landing in DONE is newer than anything pending, so it wins.
    assign start_val = ((state == DONE) && !wr) ? pend_dat : bus.binary;

`ifdef BIN_BCD_SIGNED_EN
    logic sign_w, sign_q;
    assign start_mag = start_val[BIN_W-1] ? (~start_val + BIN_W'(1)) : start_val;
    assign bus.sign  = sign_q;
`else
    assign start_mag = start_val;
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (dig_q[g*BCD_W +: BCD_W]),
            .dout (dig_adj[g*BCD_W +: BCD_W])
        );
        // Working digits are legal BCD by construction; a digit above 9 means corruption.
        assign dig_bad[g] = dig_q[g*BCD_W +: BCD_W] > 4'd9;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (wr) state_nxt = SHIFT;
            SHIFT:   if (cnt_q == '0) state_nxt = DONE;
            DONE:    state_nxt = (wr || pend_vld) ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sh_q      <= '0;
            dig_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            pend_vld  <= 1'b0;
            pend_dat  <= '0;
            dec_q     <= '0;
            ovf_out_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef BIN_BCD_SIGNED_EN
            sign_w    <= 1'b0;
            sign_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (state == DONE) begin
                dec_q     <= dig_q;
                ovf_out_q <= ovf_q;
                done_q    <= 1'b1;
`ifdef BIN_BCD_SIGNED_EN
                sign_q    <= sign_w;
`endif
            end

            if (start) begin
                sh_q  <= start_mag;
                dig_q <= '0;
                cnt_q <= CNT_W'(BIN_W - 1);
                ovf_q <= 1'b0;
`ifdef BIN_BCD_SIGNED_EN
                sign_w <= start_val[BIN_W-1];
`endif
            end else if (state == SHIFT) begin
                {dig_q, sh_q} <= {dig_adj[DEC_W-2:0], sh_q, 1'b0};
                if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                ovf_q <= ovf_q | dig_adj[DEC_W-1] | (|dig_bad);
            end

            if (state == DONE) begin
                pend_vld <= 1'b0;
            end else if (wr && (state == SHIFT)) begin
                pend_vld <= 1'b1;
                pend_dat <= bus.binary;
            end
        end
    end

    assign bus.decimal  = dec_q;
    assign bus.overflow = ovf_out_q;
    assign bus.done     = done_q;
    assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_bin_bcd_seq.sv
// Self-checking bench for bin_bcd_seq at BIN_W=27, DIGITS=8 (signed cases when BIN_BCD_SIGNED_EN is defined).
module tb_bin_bcd_seq;

    localparam int BIN_W  = 27;
    localparam int DIGITS = 8;

    typedef struct {
        logic [BIN_W-1:0] bin;
        logic [31:0]      dec;
        logic             ovf;
        logic             sgn;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   wr_cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    bin_bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

    bin_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: decimal digits by division, overflow by magnitude comparison.
    function automatic void model(input logic [BIN_W-1:0] b, output logic [31:0] dec,
                                  output logic ovf, output logic sgn);
        longint v;
        v   = longint'(b);
        sgn = 1'b0;
`ifdef BIN_BCD_SIGNED_EN
        if (b[BIN_W-1]) begin
            sgn = 1'b1;
            v   = (longint'(1) << BIN_W) - v;
        end
`endif
        ovf = (v > 64'd99999999);
        dec = '0;
        for (int i = 0; i < DIGITS; i++) begin
            dec[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
    endfunction

    function automatic logic get_sign();
`ifdef BIN_BCD_SIGNED_EN
        return bus.sign;
`else
        return 1'b0;
`endif
    endfunction

    task automatic do_write(input logic [BIN_W-1:0] v);
        @(negedge clk);
        bus.digcs    = 1'b1;
        bus.digwrite = 1'b1;
        bus.binary   = v;
        @(posedge clk);
        #1;
        wr_cyc       = cyc;
        bus.digcs    = 1'b0;
        bus.digwrite = 1'b0;
    endtask

    // Waits for done; optionally checks busy stays high until done and drops with it.
    task automatic wait_done(input bit chk_busy, output logic [31:0] dec, output logic ovf,
                             output logic sgn, output int done_cyc);
        bit seen;
        int busy_bad;
        seen     = 1'b0;
        busy_bad = 0;
        done_cyc = -1;
        dec      = '0;
        ovf      = 1'b0;
        sgn      = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                seen     = 1'b1;
                done_cyc = cyc;
                dec      = bus.decimal;
                ovf      = bus.overflow;
                sgn      = get_sign();
                if (bus.busy) busy_bad++;
                break;
            end
            if (!bus.busy) busy_bad++;
        end
        check("done_seen", 64'(seen), 64'd1);
        if (chk_busy) check("busy_window", 64'(busy_bad), 64'd0);
    endtask

    initial begin
        vec_t        tbl[8];
        logic [31:0] dec, edec;
        logic        ovf, eovf, sgn, esgn;
        int          dc, dc1, w5, bad;

`ifdef BIN_BCD_SIGNED_EN
        tbl[0] = '{27'h7FFFFFB,      32'h00000005, 1'b0, 1'b1};
        tbl[1] = '{27'h4000000,      32'h67108864, 1'b0, 1'b1};
        tbl[2] = '{27'd12345678,     32'h12345678, 1'b0, 1'b0};
        tbl[3] = '{27'd0,            32'h00000000, 1'b0, 1'b0};
        tbl[4] = '{27'h7FFFFFF,      32'h00000001, 1'b0, 1'b1};
        tbl[5] = '{27'd67108863,     32'h67108863, 1'b0, 1'b0};
        tbl[6] = '{27'd7,            32'h00000007, 1'b0, 1'b0};
        tbl[7] = '{27'h7FFFFF9,      32'h00000007, 1'b0, 1'b1};
`else
        tbl[0] = '{27'd12345678,     32'h12345678, 1'b0, 1'b0};
        tbl[1] = '{27'd0,            32'h00000000, 1'b0, 1'b0};
        tbl[2] = '{27'd99999999,     32'h99999999, 1'b0, 1'b0};
        tbl[3] = '{27'd100000000,    32'h00000000, 1'b1, 1'b0};
        tbl[4] = '{27'd7,            32'h00000007, 1'b0, 1'b0};
        tbl[5] = '{27'd134217727,    32'h34217727, 1'b1, 1'b0};
        tbl[6] = '{27'd10000000,     32'h10000000, 1'b0, 1'b0};
        tbl[7] = '{27'd4095,         32'h00004095, 1'b0, 1'b0};
`endif

        bus.digcs    = 1'b0;
        bus.digwrite = 1'b0;
        bus.binary   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_decimal", 64'(bus.decimal), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_overflow", 64'(bus.overflow), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            do_write(tbl[i].bin);
            wait_done(1'b1, dec, ovf, sgn, dc);
            check($sformatf("tbl%0d_decimal", i), 64'(dec), 64'(tbl[i].dec));
            check($sformatf("tbl%0d_overflow", i), 64'(ovf), 64'(tbl[i].ovf));
            check($sformatf("tbl%0d_sign", i), 64'(sgn), 64'(tbl[i].sgn));
            check($sformatf("tbl%0d_latency", i), 64'(dc - wr_cyc), 64'd28);
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_done_pulse", i), 64'(bus.done), 64'd0);
            check($sformatf("tbl%0d_hold", i), 64'(bus.decimal), 64'(tbl[i].dec));
        end

        // Latest pending write wins; the overwritten one never appears.
        do_write(27'd5);
        w5 = wr_cyc;
        repeat (3) @(posedge clk);
        do_write(27'd11);
        do_write(27'd22);
        wait_done(1'b0, dec, ovf, sgn, dc);
        check("pend_first_decimal", 64'(dec), 64'h5);
        check("pend_first_latency", 64'(dc - w5), 64'd28);
        dc1 = dc;
        wait_done(1'b0, dec, ovf, sgn, dc);
        check("pend_second_decimal", 64'(dec), 64'h22);
        check("pend_back_to_back", 64'(dc - dc1), 64'd28);
        bad = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) bad++;
        end
        check("pend_no_third", 64'(bad), 64'd0);

        // Reset mid-conversion.
        do_write(27'd4321);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_decimal", 64'(bus.decimal), 64'd0);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_done", 64'(bus.done), 64'd0);
        check("midrst_overflow", 64'(bus.overflow), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (35) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy || bus.decimal != '0) bad++;
        end
        check("midrst_no_remnant", 64'(bad), 64'd0);
        do_write(27'd9);
        wait_done(1'b1, dec, ovf, sgn, dc);
        check("midrst_after_decimal", 64'(dec), 64'h9);
        check("midrst_after_overflow", 64'(ovf), 64'd0);

        // Random operands against the arithmetic model.
        for (int i = 0; i < 30; i++) begin
            logic [BIN_W-1:0] v;
            v = BIN_W'($urandom_range(0, 134217727));
            model(v, edec, eovf, esgn);
            do_write(v);
            wait_done(1'b0, dec, ovf, sgn, dc);
            check($sformatf("rnd%0d_decimal v=%0d", i, v), 64'(dec), 64'(edec));
            check($sformatf("rnd%0d_overflow v=%0d", i, v), 64'(ovf), 64'(eovf));
            check($sformatf("rnd%0d_sign v=%0d", i, v), 64'(sgn), 64'(esgn));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
